pulse_peak_detector: RTL

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

---
 rtl/pulse_peak_detector.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : pulse_peak_detector
// Description : Threshold-triggered pulse detector for a filtered sample
//               stream. Each pulse (run of samples strictly above threshold)
//               yields one event carrying its peak amplitude, the timestamp of
//               that peak, the number of above-threshold samples, and a
//               pile-up flag set when the pulse hit the max_width limit.
//               Events pass through a small first-word-fall-through FIFO.
//               Events that arrive while the FIFO is full are counted in
//               lost_count.
// Ports       :
//   clk             - single clock, rising edge
//   reset           - synchronous, active-high
//   enable          - gates the start of a new pulse only
//   input_data      - filtered sample, one per clock (unsigned)
//   threshold       - trigger level (strict greater-than)
//   holdoff         - dead-time cycles after a pulse ends
//   max_width       - pile-up limit in samples (0 behaves as 1)
//   event_valid     - FIFO head holds an event
//   event_ready     - consumer accepts the head when event_valid is high
//   event_amplitude - peak sample value of the head event
//   event_time      - timestamp of the peak sample of the head event
//   event_width     - above-threshold sample count of the head event
//   event_pileup    - head event was terminated by max_width
//   lost_count      - saturating count of events dropped on FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_peak_detector #(
  parameter int SIZE_DATA  = 16,
  parameter int SIZE_TIME  = 32,
  parameter int SIZE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SIZE_DATA-1:0]  input_data,
  input  logic [SIZE_DATA-1:0]  threshold,
  input  logic [SIZE_WIDTH-1:0] holdoff,
  input  logic [SIZE_WIDTH-1:0] max_width,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [SIZE_DATA-1:0]  event_amplitude,
  output logic [SIZE_TIME-1:0]  event_time,
  output logic [SIZE_WIDTH-1:0] event_width,
  output logic                  event_pileup,
  output logic [15:0]           lost_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SIZE_WIDTH-1:0] WIDTH_ONE = SIZE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SIZE_DATA-1:0]  amp;
    logic [SIZE_TIME-1:0]  tstamp;
    logic [SIZE_WIDTH-1:0] width;
    logic                  pileup;
  } event_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [SIZE_TIME-1:0]  ts_q, ts_d;
  logic [SIZE_DATA-1:0]  peak_q, peak_d;
  logic [SIZE_TIME-1:0]  peak_time_q, peak_time_d;
  logic [SIZE_WIDTH-1:0] width_q, width_d;
  logic [SIZE_WIDTH-1:0] hold_cnt_q, hold_cnt_d;

  // One-entry staging register between the detector and the FIFO; this is
  // what places the FIFO write one edge after the terminating sample.
  logic                  emit_q, emit_d;
  event_t                emit_ev_q, emit_ev_d;

  // FIFO storage plus a registered head stage. Occupancy is the stored count
  // plus the head register, capped at FIFO_DEPTH in total.
  event_t                mem_q [FIFO_DEPTH];
  event_t                mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  head_valid_q, head_valid_d;
  event_t                head_q, head_d;
  logic [15:0]           lost_q, lost_d;

  // --------------------------------------------------------------------------
  // Detector datapath helpers
  // --------------------------------------------------------------------------
  logic                  above;
  logic [SIZE_WIDTH-1:0] width_limit;
  logic [SIZE_WIDTH-1:0] width_inc;
  logic [SIZE_WIDTH:0]   hold_inc;

  assign above       = (input_data > threshold);
  assign width_limit = (max_width == '0) ? WIDTH_ONE : max_width;
  assign width_inc   = width_q + WIDTH_ONE;
  assign hold_inc    = {1'b0, hold_cnt_q} + (SIZE_WIDTH+1)'(1);
  assign ts_d        = ts_q + SIZE_TIME'(1);

  // --------------------------------------------------------------------------
  // Detector FSM: next state and event capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    peak_time_d = peak_time_q;
    width_d     = width_q;
    hold_cnt_d  = hold_cnt_q;
    emit_d      = 1'b0;
    emit_ev_d   = emit_ev_q;

    case (state_q)
      ST_IDLE: begin
        if (enable && above) begin
          peak_d      = input_data;
          peak_time_d = ts_q;
          width_d     = WIDTH_ONE;
          // A limit of one sample is reached by the very first sample.
          if (width_limit == WIDTH_ONE) begin
            emit_d           = 1'b1;
            emit_ev_d.amp    = input_data;
            emit_ev_d.tstamp = ts_q;
            emit_ev_d.width  = WIDTH_ONE;
            emit_ev_d.pileup = 1'b1;
            state_d          = ST_WAIT_LOW;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end

      ST_ACTIVE: begin
        if (above) begin
          width_d = width_inc;
          // Strict compare: the earliest of equal maxima keeps its timestamp.
          if (input_data > peak_q) begin
            peak_d      = input_data;
            peak_time_d = ts_q;
          end
          if (width_inc >= width_limit) begin
            emit_d           = 1'b1;
            emit_ev_d.amp    = peak_d;
            emit_ev_d.tstamp = peak_time_d;
            emit_ev_d.width  = width_inc;
            emit_ev_d.pileup = 1'b1;
            state_d          = ST_WAIT_LOW;
          end
        end else begin
          emit_d           = 1'b1;
          emit_ev_d.amp    = peak_q;
          emit_ev_d.tstamp = peak_time_q;
          emit_ev_d.width  = width_q;
          emit_ev_d.pileup = 1'b0;
          hold_cnt_d       = '0;
          state_d          = ST_HOLDOFF;
        end
      end

      ST_WAIT_LOW: begin
        if (!above) begin
          hold_cnt_d = '0;
          state_d    = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        // The edge leaving HOLDOFF is itself the first counted dead cycle,
        // so holdoff of 0 or 1 both return to IDLE on the next edge.
        if (hold_inc >= {1'b0, holdoff}) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_inc[SIZE_WIDTH-1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event FIFO control
  // --------------------------------------------------------------------------
  logic             pop;
  logic             push;
  logic             drop;
  logic             load;
  logic             full_blocked;
  logic [CNT_W-1:0] occupancy;

  assign pop          = head_valid_q && event_ready;
  assign occupancy    = count_q + CNT_W'(head_valid_q);
  // A pop on the same edge frees a slot, so a full FIFO still takes the push.
  assign full_blocked = (occupancy == CNT_W'(FIFO_DEPTH)) && !pop;
  assign push         = emit_q && !full_blocked;
  assign drop         = emit_q && full_blocked;
  assign load         = (count_q != '0) && (!head_valid_q || pop);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = emit_ev_q;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(load);
    count_d      = count_q + CNT_W'(push) - CNT_W'(load);
    head_valid_d = head_valid_q;
    head_d       = head_q;
    lost_d       = lost_q;

    if (load) begin
      head_valid_d = 1'b1;
      head_d       = mem_q[rd_ptr_q];
    end else if (pop) begin
      // Head fields are left untouched so outputs hold when empty.
      head_valid_d = 1'b0;
    end

    if (drop && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ts_q         <= '0;
      peak_q       <= '0;
      peak_time_q  <= '0;
      width_q      <= '0;
      hold_cnt_q   <= '0;
      emit_q       <= 1'b0;
      emit_ev_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
      lost_q       <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      peak_q       <= peak_d;
      peak_time_q  <= peak_time_d;
      width_q      <= width_d;
      hold_cnt_q   <= hold_cnt_d;
      emit_q       <= emit_d;
      emit_ev_q    <= emit_ev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      lost_q       <= lost_d;
    end
  end

  // Storage array is only ever read behind count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign event_valid     = head_valid_q;
  assign event_amplitude = head_q.amp;
  assign event_time      = head_q.tstamp;
  assign event_width     = head_q.width;
  assign event_pileup    = head_q.pileup;
  assign lost_count      = lost_q;

endmodule
`default_nettype wire
